// File: rtl/ahb_apb_pkg.sv
// Shared types for the AHB-Lite to APB bridge.
package ahb_apb_pkg;

    // AHB HTRANS encodings
    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    // Bridge sequencing: WWAIT is the AHB write data phase, SETUP/ENABLE the APB access
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WWAIT  = 2'b01,
        ST_SETUP  = 2'b10,
        ST_ENABLE = 2'b11
    } bridge_state_t;

endpackage

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge, single clock, one-deep pending slot
// so an address phase overlapping a write data phase is not lost.
module ahb_apb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HRESP,
    output logic                  HREADY_OUT,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA
);
    import ahb_apb_pkg::*;

    bridge_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr, pend_addr;
    logic                  cur_write, pend_write, pend_valid;
    logic [DATA_WIDTH-1:0] wdata;
    htrans_t               htrans;
    logic                  hready, accept;
    logic                  load_bus, load_pend, fill_pend, cap_wdata;

    assign htrans = htrans_t'(HTRANS);

    // Stall only in SETUP, and in ENABLE while a queued transfer still has to issue
    assign hready = (state_q != ST_SETUP) && !((state_q == ST_ENABLE) && pend_valid);
    assign accept = HSEL && (htrans == HT_NONSEQ || htrans == HT_SEQ) && hready;

    // Next-state and APB control decode
    always_comb begin
        state_d   = state_q;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        load_bus  = 1'b0;
        load_pend = 1'b0;
        fill_pend = 1'b0;
        cap_wdata = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load_bus = 1'b1;
                    state_d  = HWRITE ? ST_WWAIT : ST_SETUP;
                end
            end
            ST_WWAIT: begin
                cap_wdata = 1'b1;
                fill_pend = accept;
                state_d   = ST_SETUP;
            end
            ST_SETUP: begin
                PSEL    = 1'b1;
                state_d = ST_ENABLE;
            end
            ST_ENABLE: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (pend_valid) begin
                    load_pend = 1'b1;
                    state_d   = pend_write ? ST_WWAIT : ST_SETUP;
                end else if (accept) begin
                    load_bus = 1'b1;
                    state_d  = HWRITE ? ST_WWAIT : ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Current APB access: loaded from the bus or from the pending slot, write data from WWAIT
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cur_addr  <= '0;
            cur_write <= 1'b0;
            wdata     <= '0;
        end else begin
            if (load_bus) begin
                cur_addr  <= HADDR;
                cur_write <= HWRITE;
            end else if (load_pend) begin
                cur_addr  <= pend_addr;
                cur_write <= pend_write;
            end
            if (cap_wdata) wdata <= HWDATA;
        end
    end

    // Pending slot: fills only during WWAIT, drains in ENABLE; never both at once
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_write <= 1'b0;
        end else if (fill_pend) begin
            pend_valid <= 1'b1;
            pend_addr  <= HADDR;
            pend_write <= HWRITE;
        end else if (load_pend) begin
            pend_valid <= 1'b0;
        end
    end

    assign HREADY_OUT = hready;
    assign HRESP      = 1'b0;
    assign HRDATA     = PRDATA;
    assign PADDR      = cur_addr;
    assign PWRITE     = cur_write;
    assign PWDATA     = wdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: AHB master driver with a transfer queue, APB memory
// slave, and a reference model (flat memory array updated in program order).
module tb_ahb_apb_bridge;

    logic        HCLK = 1'b0;
    logic        HRESET, HSEL, HWRITE;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR, HWDATA, HRDATA, PRDATA, PADDR, PWDATA;
    logic        HRESP, HREADY_OUT, PSEL, PENABLE, PWRITE;

    ahb_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP),
        .HREADY_OUT(HREADY_OUT), .PRDATA(PRDATA), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA)
    );

    always #5 HCLK = ~HCLK;

    // APB memory slave, no wait states
    logic [31:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    always @(posedge HCLK) if (PSEL && PENABLE && PWRITE) mem[PADDR[9:2]] <= PWDATA;
    assign PRDATA = mem[PADDR[9:2]];

    typedef struct {
        bit          act;
        bit          wr;
        bit          sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [31:0] data;
    } item_t;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] data;
    } apb_t;

    item_t       stream [$];
    apb_t        exp_log [$], got_log [$];
    logic [31:0] exp_rd [$], got_rd [$];
    logic [31:0] model [0:255];
    int          n_cmp = 0, n_bad = 0, proto_err = 0;

    // APB monitor: every ENABLE must follow a SETUP with identical address/direction/data
    initial begin
        bit          prev_setup;
        logic [31:0] s_addr, s_wd;
        bit          s_wr;
        apb_t        e;
        prev_setup = 0; s_addr = 0; s_wd = 0; s_wr = 0;
        forever begin
            @(negedge HCLK);
            if (HRESET) prev_setup = 0;
            else begin
                if (HRESP !== 1'b0) proto_err++;
                if (PSEL && PENABLE) begin
                    if (!prev_setup || PADDR !== s_addr || PWRITE !== s_wr || (PWRITE && PWDATA !== s_wd))
                        proto_err++;
                    e.addr = PADDR; e.wr = PWRITE; e.data = PWRITE ? PWDATA : PRDATA;
                    got_log.push_back(e);
                end
                prev_setup = PSEL && !PENABLE;
                s_addr = PADDR; s_wr = PWRITE; s_wd = PWDATA;
            end
        end
    end

    task automatic tick();
        @(posedge HCLK); #1;
    endtask

    task automatic bus_idle();
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HADDR = 32'h0;
    endtask

    task automatic clear_logs();
        exp_log.delete(); got_log.delete(); exp_rd.delete(); got_rd.delete(); stream.delete();
    endtask

    // Queue a transfer and predict its APB effect from the model memory
    task automatic push_op(input bit w, input logic [31:0] a, input logic [31:0] d);
        item_t it;
        apb_t  e;
        it.act = 1; it.wr = w; it.sel = 1; it.addr = a; it.data = d;
        it.trans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
        stream.push_back(it);
        e.addr = a; e.wr = w;
        if (w) begin
            model[a[9:2]] = d;
            e.data = d;
        end else begin
            e.data = model[a[9:2]];
            exp_rd.push_back(model[a[9:2]]);
        end
        exp_log.push_back(e);
    endtask

    // Queue a cycle the bridge must ignore (deselected, or IDLE/BUSY)
    task automatic push_idle();
        item_t it;
        it.act = 0;
        it.sel = 1'($urandom_range(0, 1));
        it.trans = it.sel ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
        it.wr = 1'($urandom_range(0, 1));
        it.addr = 32'($urandom_range(0, 15)) << 2;
        it.data = 0;
        stream.push_back(it);
    endtask

    task automatic drive_item(input item_t it);
        HSEL = it.sel; HTRANS = it.trans; HWRITE = it.wr; HADDR = it.addr;
    endtask

    // AHB master: address phase 'a' advances, and 'd' completes, only on HREADY_OUT=1
    task automatic run_stream(input int budget, output bit timed_out);
        item_t a, d, none;
        bit    hr;
        int    n;
        none.act = 0; none.sel = 0; none.trans = 2'b00; none.wr = 0; none.addr = 0; none.data = 0;
        d = none;
        a = (stream.size() > 0) ? stream.pop_front() : none;
        drive_item(a);
        n = 0;
        while (n < budget && (stream.size() > 0 || a.act || d.act)) begin
            HWDATA = (d.act && d.wr) ? d.data : $urandom;
            hr = HREADY_OUT;
            if (hr && d.act && !d.wr) got_rd.push_back(HRDATA);
            tick();
            n++;
            if (hr) begin
                d = a;
                a = (stream.size() > 0) ? stream.pop_front() : none;
                drive_item(a);
            end
        end
        timed_out = (n >= budget);
        bus_idle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        HRESET = 1; bus_idle(); HWDATA = 0;
        repeat (3) tick();
        n_cmp++;
        if ({HREADY_OUT, PSEL, PENABLE, HRESP, PWRITE} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 10000", {HREADY_OUT, PSEL, PENABLE, HRESP, PWRITE});
        end
        n_cmp++;
        if ({PADDR, PWDATA} !== 64'h0) begin
            n_bad++; $display("FAIL reset_regs: got %h want 0", {PADDR, PWDATA});
        end
        HRESET = 0;
        tick();
    endtask

    task automatic test_single();
        clear_logs();
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h04;
        tick();
        bus_idle(); HWDATA = 32'hBEEF_BEEF;
        n_cmp++;
        if ({PSEL, HREADY_OUT} !== 2'b01) begin
            n_bad++; $display("FAIL single_wwait: got %b want 01", {PSEL, HREADY_OUT});
        end
        tick();
        HWDATA = $urandom;
        n_cmp++;
        if ({PSEL, PENABLE, HREADY_OUT, PWRITE} !== 4'b1001 || PADDR !== 32'h04 || PWDATA !== 32'hBEEF_BEEF) begin
            n_bad++; $display("FAIL single_wsetup: got %b %h %h want 1001 4 beefbeef",
                              {PSEL, PENABLE, HREADY_OUT, PWRITE}, PADDR, PWDATA);
        end
        tick();
        n_cmp++;
        if ({PSEL, PENABLE, HREADY_OUT} !== 3'b111 || PWDATA !== 32'hBEEF_BEEF) begin
            n_bad++; $display("FAIL single_wenable: got %b %h want 111 beefbeef", {PSEL, PENABLE, HREADY_OUT}, PWDATA);
        end
        tick();
        model[1] = 32'hBEEF_BEEF;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h04;
        n_cmp++;
        if ({PSEL, HREADY_OUT} !== 2'b01) begin
            n_bad++; $display("FAIL single_wdone: got %b want 01", {PSEL, HREADY_OUT});
        end
        tick();
        bus_idle();
        n_cmp++;
        if ({PSEL, PENABLE, HREADY_OUT, PWRITE} !== 4'b1000 || PADDR !== 32'h04) begin
            n_bad++; $display("FAIL single_rsetup: got %b %h want 1000 4", {PSEL, PENABLE, HREADY_OUT, PWRITE}, PADDR);
        end
        tick();
        n_cmp++;
        if ({PSEL, PENABLE, HREADY_OUT} !== 3'b111 || HRDATA !== 32'hBEEF_BEEF) begin
            n_bad++; $display("FAIL single_renable: got %b %h want 111 beefbeef", {PSEL, PENABLE, HREADY_OUT}, HRDATA);
        end
        tick();
        n_cmp++;
        if (PSEL !== 1'b0 || got_log.size() != 2) begin
            n_bad++; $display("FAIL single_count: got psel %b accesses %0d want 0 2", PSEL, got_log.size());
        end
    endtask

    task automatic test_hsel_idle();
        bit bad;
        bad = 0;
        HSEL = 0; HTRANS = 2'b00; HWRITE = 1; HADDR = 32'h40;
        repeat (2) begin
            tick();
            if ({PSEL, PENABLE, HREADY_OUT} !== 3'b001) bad = 1;
        end
        HTRANS = 2'b10;
        repeat (2) begin
            tick();
            if ({PSEL, PENABLE, HREADY_OUT} !== 3'b001) bad = 1;
        end
        bus_idle();
        tick();
        if ({PSEL, PENABLE} !== 2'b00) bad = 1;
        n_cmp++;
        if (bad) begin
            n_bad++; $display("FAIL hsel_idle: got activity %b want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        clear_logs();
        push_op(1, 32'h04, 32'hDEAD_BEEF);
        push_op(1, 32'h08, 32'hBEEF_CAFE);
        push_op(1, 32'h0C, 32'hFACE_FEED);
        push_op(0, 32'h0C, 32'h0);
        run_stream(200, to);
        n_cmp++;
        if (to || got_log.size() != exp_log.size()) begin
            n_bad++; $display("FAIL b2b_count: got %0d (timeout %b) want %0d", got_log.size(), to, exp_log.size());
        end
        for (int i = 0; i < exp_log.size() && i < got_log.size(); i++) begin
            n_cmp++;
            if ({got_log[i].addr, got_log[i].wr, got_log[i].data} !== {exp_log[i].addr, exp_log[i].wr, exp_log[i].data}) begin
                n_bad++; $display("FAIL b2b_apb[%0d]: got %h/%b/%h want %h/%b/%h", i, got_log[i].addr, got_log[i].wr,
                                  got_log[i].data, exp_log[i].addr, exp_log[i].wr, exp_log[i].data);
            end
        end
        n_cmp++;
        if (got_rd.size() != 1 || got_rd[0] !== 32'hFACE_FEED) begin
            n_bad++; $display("FAIL b2b_read: got %0d reads first %h want facefeed", got_rd.size(),
                              got_rd.size() > 0 ? got_rd[0] : 32'hx);
        end
    endtask

    task automatic test_pipelined();
        bit to;
        clear_logs();
        push_op(1, 32'h10, 32'h0000_1234);
        push_op(1, 32'h14, 32'h0000_4321);
        push_op(0, 32'h10, 32'h0);
        push_op(0, 32'h14, 32'h0);
        push_op(1, 32'h18, 32'h1234_5678);
        push_op(0, 32'h18, 32'h0);
        push_op(0, 32'h1C, 32'h0);
        push_op(1, 32'h1C, 32'hC0FF_EE00);
        push_op(0, 32'h1C, 32'h0);
        run_stream(300, to);
        n_cmp++;
        if (to || got_log.size() != exp_log.size() || got_rd.size() != exp_rd.size()) begin
            n_bad++; $display("FAIL pipe_count: got %0d/%0d (timeout %b) want %0d/%0d", got_log.size(), got_rd.size(),
                              to, exp_log.size(), exp_rd.size());
        end
        for (int i = 0; i < exp_log.size() && i < got_log.size(); i++) begin
            n_cmp++;
            if ({got_log[i].addr, got_log[i].wr, got_log[i].data} !== {exp_log[i].addr, exp_log[i].wr, exp_log[i].data}) begin
                n_bad++; $display("FAIL pipe_apb[%0d]: got %h/%b/%h want %h/%b/%h", i, got_log[i].addr, got_log[i].wr,
                                  got_log[i].data, exp_log[i].addr, exp_log[i].wr, exp_log[i].data);
            end
        end
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
            n_cmp++;
            if (got_rd[i] !== exp_rd[i]) begin
                n_bad++; $display("FAIL pipe_rd[%0d]: got %h want %h", i, got_rd[i], exp_rd[i]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        clear_logs();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 3) push_idle();
            else push_op(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
        end
        run_stream(5000, to);
        n_cmp++;
        if (to || got_log.size() != exp_log.size() || got_rd.size() != exp_rd.size()) begin
            n_bad++; $display("FAIL rand_count: got %0d/%0d (timeout %b) want %0d/%0d", got_log.size(), got_rd.size(),
                              to, exp_log.size(), exp_rd.size());
        end
        for (int i = 0; i < exp_log.size() && i < got_log.size(); i++) begin
            n_cmp++;
            if ({got_log[i].addr, got_log[i].wr, got_log[i].data} !== {exp_log[i].addr, exp_log[i].wr, exp_log[i].data}) begin
                n_bad++; $display("FAIL rand_apb[%0d]: got %h/%b/%h want %h/%b/%h", i, got_log[i].addr, got_log[i].wr,
                                  got_log[i].data, exp_log[i].addr, exp_log[i].wr, exp_log[i].data);
            end
        end
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
            n_cmp++;
            if (got_rd[i] !== exp_rd[i]) begin
                n_bad++; $display("FAIL rand_rd[%0d]: got %h want %h", i, got_rd[i], exp_rd[i]);
            end
        end
        n_cmp++;
        if (proto_err != 0) begin
            n_bad++; $display("FAIL apb_protocol: got %0d violations want 0", proto_err);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        clear_logs();
        // read aborted in SETUP
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h20;
        tick();
        bus_idle();
        n_cmp++;
        if ({PSEL, PENABLE} !== 2'b10) begin
            n_bad++; $display("FAIL rstmid_setup: got %b want 10", {PSEL, PENABLE});
        end
        HRESET = 1;
        tick();
        HRESET = 0;
        n_cmp++;
        if ({PSEL, PENABLE, HREADY_OUT} !== 3'b001) begin
            n_bad++; $display("FAIL rstmid_abort: got %b want 001", {PSEL, PENABLE, HREADY_OUT});
        end
        tick();
        // write with a queued read, reset in the write's SETUP drops both
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h20;
        tick();
        HWDATA = 32'h5555_AAAA; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h24;
        tick();
        bus_idle();
        HRESET = 1;
        tick();
        HRESET = 0;
        bad = ({PSEL, PENABLE, HREADY_OUT} !== 3'b001);
        repeat (3) begin
            tick();
            if ({PSEL, PENABLE, HREADY_OUT} !== 3'b001) bad = 1;
        end
        n_cmp++;
        if (bad || got_log.size() != 0) begin
            n_bad++; $display("FAIL rstmid_pending: got activity %b accesses %0d want 0 0", bad, got_log.size());
        end
        // FSM restarts from IDLE: a read goes straight to SETUP
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h24;
        tick();
        bus_idle();
        n_cmp++;
        if ({PSEL, PENABLE, HREADY_OUT} !== 3'b100 || PADDR !== 32'h24) begin
            n_bad++; $display("FAIL rstmid_restart: got %b %h want 100 24", {PSEL, PENABLE, HREADY_OUT}, PADDR);
        end
        tick();
        n_cmp++;
        if (HRDATA !== model[9]) begin
            n_bad++; $display("FAIL rstmid_read: got %h want %h", HRDATA, model[9]);
        end
        repeat (2) tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        HRESET = 1; HWDATA = 0; bus_idle();
        test_reset();
        test_single();
        test_hsel_idle();
        test_back_to_back();
        test_pipelined();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
